// File: rtl/mod_sub_1r_2c_pkg.sv
// Channel-arithmetic constants shared by the residue-channel adders and subtractors.
package mod_sub_1r_2c_pkg;

    localparam int RES_W    = 18;
    localparam int MOD_3_11 = 177147;

    typedef logic [RES_W-1:0] residue_t;

    // A channel modulus must be at least 2 and representable in the residue width.
    function automatic logic modulus_fits(input int modulus, input int width);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/mod_sub_core.sv
// Combinational modular-subtract datapath: raw difference with borrow, and borrow correction.
module mod_sub_core
    import mod_sub_1r_2c_pkg::*;
#(
    parameter int DATA_WIDTH = RES_W,
    parameter int MODULUS    = MOD_3_11
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrow,
    input  logic [DATA_WIDTH-1:0] diff_in,
    input  logic                  borrow_in,
    output logic [DATA_WIDTH-1:0] corrected
);

    // A modulus of exactly 2^DATA_WIDTH truncates to zero, which is the correct wrap.
    localparam logic [DATA_WIDTH-1:0] MOD_T = DATA_WIDTH'(MODULUS);

    logic [DATA_WIDTH:0] wide;

    always_comb begin
        wide   = {1'b0, a} - {1'b0, b};
        diff   = wide[DATA_WIDTH-1:0];
        borrow = wide[DATA_WIDTH];
    end

    always_comb begin
        corrected = borrow_in ? (diff_in + MOD_T) : diff_in;
    end

endmodule

// File: rtl/mod_sub_1r_2c.sv
// Two-stage registered modular subtractor for one RNS residue channel: result = (A - B) mod MODULUS.
module mod_sub_1r_2c
    import mod_sub_1r_2c_pkg::*;
#(
    parameter int DATA_WIDTH = RES_W,
    parameter int MODULUS    = MOD_3_11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] result
);

    if (!modulus_fits(MODULUS, DATA_WIDTH)) begin : g_bad_modulus
        $error("mod_sub_1r_2c: MODULUS must satisfy 2 <= MODULUS <= 2^DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] diff_p0;
    logic                  borrow_p0;
    logic [DATA_WIDTH-1:0] diff_p1;
    logic                  borrow_p1;
    logic [DATA_WIDTH-1:0] result_p1;

    mod_sub_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODULUS    (MODULUS)
    ) u_core (
        .a         (A),
        .b         (B),
        .diff      (diff_p0),
        .borrow    (borrow_p0),
        .diff_in   (diff_p1),
        .borrow_in (borrow_p1),
        .corrected (result_p1)
    );

    // Stage 1: raw difference and borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_p1   <= '0;
            borrow_p1 <= 1'b0;
        end else begin
            diff_p1   <= diff_p0;
            borrow_p1 <= borrow_p0;
        end
    end

    // Stage 2: modulus-corrected result.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= result_p1;
        end
    end

endmodule

// File: tb/tb_mod_sub_1r_2c.sv
// Bench for mod_sub_1r_2c: default 18-bit channel plus an 8-bit / 251 override instance.
module tb_mod_sub_1r_2c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, rst_s;
    logic [17:0] a_b, b_b, res_b;
    logic [7:0]  a_s, b_s, res_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int    exp;
        string tag;
    } sb_t;

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    sb_t  qb[$];
    sb_t  qs[$];
    vec_t vecs[12];

    mod_sub_1r_2c dut_big (
        .clk    (clk),
        .rst    (rst_b),
        .A      (a_b),
        .B      (b_b),
        .result (res_b)
    );

    mod_sub_1r_2c #(
        .DATA_WIDTH (8),
        .MODULUS    (251)
    ) dut_small (
        .clk    (clk),
        .rst    (rst_s),
        .A      (a_s),
        .B      (b_s),
        .result (res_s)
    );

    function automatic int ref_sub(input int a, input int b, input int m, input int w);
        int mask;
        int d;
        mask = (1 << w) - 1;
        d    = (a - b) & mask;
        if (a < b) d = (d + m) & mask;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: result=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard holds [result stage, stage 1]; each edge shifts it, reset zeroes both.
    task automatic step_big(input logic r, input int a, input int b, input int exp, input string tag);
        sb_t e;
        rst_b = r;
        a_b   = 18'(a);
        b_b   = 18'(b);
        @(posedge clk);
        if (r) begin
            qb.delete();
            qb.push_back('{0, "reset"});
            qb.push_back('{0, "reset"});
        end else begin
            if (qb.size() > 0) e = qb.pop_front();
            qb.push_back('{exp, tag});
        end
        #1;
        e = qb[0];
        check(e.tag, {14'b0, res_b}, e.exp);
    endtask

    task automatic step_small(input logic r, input int a, input int b, input int exp);
        sb_t e;
        rst_s = r;
        a_s   = 8'(a);
        b_s   = 8'(b);
        @(posedge clk);
        if (r) begin
            qs.delete();
            qs.push_back('{0, "small_reset"});
            qs.push_back('{0, "small_reset"});
        end else begin
            if (qs.size() > 0) e = qs.pop_front();
            qs.push_back('{exp, $sformatf("small_%0d-%0d", a, b)});
        end
        #1;
        e = qs[0];
        check(e.tag, {24'b0, res_s}, e.exp);
    endtask

    initial begin
        vecs[0]  = '{0,      1,      177146};
        vecs[1]  = '{0,      2,      177145};
        vecs[2]  = '{2,      2,      0};
        vecs[3]  = '{2,      1,      1};
        vecs[4]  = '{100000, 100001, 177146};
        vecs[5]  = '{177146, 0,      177146};
        vecs[6]  = '{0,      177146, 1};
        vecs[7]  = '{177146, 177146, 0};
        vecs[8]  = '{262143, 0,      262143};
        vecs[9]  = '{0,      262143, 177148};
        vecs[10] = '{200000, 177147, 22853};
        vecs[11] = '{5,      177147, 5};

        rst_b = 1'b1; a_b = '0; b_b = '0;
        rst_s = 1'b1; a_s = '0; b_s = '0;

        fork
            begin : big_channel
                int bv;
                step_big(1'b1, 0, 0, 0, "");
                step_big(1'b1, 7, 3, 0, "");
                for (int i = 0; i < 12; i++)
                    step_big(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
                for (int av = 0; av < 177147; av += 97) begin
                    for (int k = 0; k < 4; k++) begin
                        bv = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 177146 : int'($urandom_range(0, 177146));
                        step_big(1'b0, av, bv, ref_sub(av, bv, 177147, 18), $sformatf("sweep_%0d-%0d", av, bv));
                    end
                end
                for (int i = 0; i < 6; i++) begin
                    int ra, rb;
                    ra = int'($urandom_range(0, 177146));
                    rb = int'($urandom_range(0, 177146));
                    step_big(1'b0, ra, rb, ref_sub(ra, rb, 177147, 18), "pre_reset");
                end
                step_big(1'b1, 12345, 54321, 0, "");
                step_big(1'b0, 10, 20, 177137, "post_reset_first");
                step_big(1'b0, 20, 10, 10, "post_reset_second");
                step_big(1'b0, 0, 0, 0, "flush");
                step_big(1'b0, 0, 0, 0, "flush");
            end
            begin : small_channel
                step_small(1'b1, 0, 0, 0);
                step_small(1'b1, 0, 0, 0);
                for (int av = 0; av < 251; av++)
                    for (int bw = 0; bw < 251; bw++)
                        step_small(1'b0, av, bw, (av < bw) ? (av - bw + 251) : (av - bw));
                step_small(1'b0, 0, 0, 0);
                step_small(1'b0, 0, 0, 0);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
